logisim_run_controller: RTL and testbench
=========================================

# logisim_run_controller

Run/step sequencer that drives the CPU clock tree. It replaces the bare free-running tick source in the FPGA top-level shell, sitting between the board inputs (GO button, run/step switch, speed switch) and `LogisimClockComponent`. It issues one-cycle `ClockTick` pulses at one of two programmable rates, or exactly one pulse per button press in single-step mode. It also freezes the CPU permanently when the core reports a halt.

## Interface
Parameters:
- `NrOfBits`, 32, width of the rate down-counter
- `FastReload`, 3125000, tick period in `GlobalClock` cycles when `pinlv`=1
- `SlowReload`, 25000000, tick period in cycles when `pinlv`=0
- `DebounceCycles`, 250000, consecutive stable synchronized samples required to accept a GO level change

Ports:
- `GlobalClock`  in  1  board clock; the only clock
- `RST`  in  1  synchronous, active-high reset
- `GO`  in  1  raw, asynchronous push-button
- `RunMode`  in  1  1 = free run, 0 = single step; synchronized internally
- `pinlv`  in  1  rate select; synchronized internally
- `Halt`  in  1  CPU halt request, synchronous to `GlobalClock`
- `ClockTick`  out  1  registered one-cycle pulse to `LogisimClockComponent.ClockTick`
- `Running`  out  1  registered; high while in RUN
- `Halted`  out  1  registered; high while in HALTED
- `StepCount`  out  16  registered count of issued ticks

## Operation
- Input conditioning:
  - `GO`, `RunMode` and `pinlv` each pass through a 2-FF synchronizer.
  - Synchronized `GO` feeds the debounce filter, then a rising-edge detector that produces the internal one-cycle `go_pulse`.
- States: IDLE, RUN, STEP, HALTED. Reset enters IDLE.
- IDLE:
  - `go_pulse` with `RunMode`=1 → RUN; load the counter with the selected reload minus 1.
  - `go_pulse` with `RunMode`=0 → STEP.
- RUN:
  - The counter decrements every cycle.
  - At 0, assert `ClockTick` for one cycle and reload from the current `pinlv` selection. A `pinlv` change takes effect only at reload.
  - `go_pulse` → IDLE (pause). `RunMode`=0 → IDLE.
- STEP: lasts exactly one cycle with `ClockTick`=1, then returns to IDLE.
- HALTED:
  - Entered when `Halt`=1 in any state. No ticks are issued.
  - Left only via `RST`; `go_pulse` is ignored.
- Priority, highest first: RST, Halt, go_pulse, RunMode change, counter expiry.
  - Halt in the same cycle as counter expiry suppresses that tick.
  - `go_pulse` in the same cycle as expiry in RUN: the tick is issued, and the state goes to IDLE.
- `StepCount` increments on every cycle in which `ClockTick`=1. It wraps from 0xFFFF to 0x0000.
- Reload values below 1 are illegal. `FastReload`=1 gives a tick every cycle.

## Timing
- Reset values: `ClockTick`=0, `Running`=0, `Halted`=0, `StepCount`=0, counter=0, debounce state=0, synchronizers=0.
- `RST` mid-RUN: the next edge returns to IDLE with all outputs at reset values. An in-flight tick is dropped.
- `go_pulse` latency: 2 (sync) + `DebounceCycles` + 1 (edge) cycles after `GO` rises and stays stable.
- RUN: the first `ClockTick` is asserted exactly R cycles after the cycle in which the state becomes RUN (R = selected reload). The period is then exactly R cycles.
- STEP: `ClockTick` is high in the cycle after the `go_pulse` cycle.
- `Running` and `Halted` reflect the current state, with no extra lag.
- `Halt` → `Halted`=1 one cycle later. No `ClockTick` appears in that cycle or later.

## Configuration
- `LOGISIM_DEBOUNCE_EN` defined: full debounce filter with a `DebounceCycles` counter, as above.
- Not defined: the filter is removed and `go_pulse` is the rising edge of the synchronized `GO`, with latency 3 cycles. `DebounceCycles` is unused. This is intended for simulation and Logisim-equivalence runs.

## Test plan
All scenarios use `FastReload`=4, `SlowReload`=10, `DebounceCycles`=3, with `LOGISIM_DEBOUNCE_EN` defined.

- **Debounce:** RST, then `RunMode`=1, `pinlv`=1, GO pulse of 8 cycles → `Running`=1 at cycle 7 after GO rises. Ticks at +4, +8, +12. `StepCount`=3 after the third tick.
- **Single step:** `RunMode`=0, three clean GO presses, plus one 2-cycle glitch → exactly 3 single-cycle ticks, `StepCount`=3, state IDLE each time. The glitch is rejected.
- **Rate switch and pause:** in RUN, toggle `pinlv` 1→0 mid-count → the current 4-cycle period completes, then ticks every 10 cycles. A second GO press → IDLE, no further ticks.
- **Halt priority:** assert `Halt` in the same cycle the counter hits 0 → no tick. `Halted`=1 next cycle. A GO press has no effect. Then RST → `Halted`=0, `StepCount`=0.
- **Wrap:** force 65536 ticks with `FastReload`=1 → `StepCount` returns to 0x0000.
- **Reset mid-RUN:** RST asserted one cycle before an expected tick → no tick, all outputs 0 on the next edge.

Source files
------------

// File: rtl/logisim_run_controller.sv
// rtl/logisim_run_controller.sv - run/step tick sequencer feeding LogisimClockComponent
// Optional GO debounce filter is enabled by defining LOGISIM_DEBOUNCE_EN.
module logisim_run_controller #(
  parameter int          NrOfBits       = 32,
  parameter int unsigned FastReload     = 3125000,
  parameter int unsigned SlowReload     = 25000000,
  parameter int unsigned DebounceCycles = 250000
) (
  input  logic        GlobalClock,
  input  logic        RST,
  input  logic        GO,
  input  logic        RunMode,
  input  logic        pinlv,
  input  logic        Halt,
  output logic        ClockTick,
  output logic        Running,
  output logic        Halted,
  output logic [15:0] StepCount
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_HALTED
  } state_e;

  localparam logic [NrOfBits-1:0] FAST_LOAD = NrOfBits'(FastReload - 1);
  localparam logic [NrOfBits-1:0] SLOW_LOAD = NrOfBits'(SlowReload - 1);

  logic [1:0]          go_sync_q, go_sync_d;
  logic [1:0]          run_sync_q, run_sync_d;
  logic [1:0]          lv_sync_q, lv_sync_d;
  logic                go_level;
  logic                go_prev_q, go_prev_d;
  logic                go_pulse_q, go_pulse_d;

  state_e              state_q, state_d;
  logic [NrOfBits-1:0] cnt_q, cnt_d;
  logic [NrOfBits-1:0] reload;
  logic                tick_q, tick_d;
  logic                running_q, running_d;
  logic                halted_q, halted_d;
  logic [15:0]         step_count_q, step_count_d;

`ifdef LOGISIM_DEBOUNCE_EN
  localparam int DW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;

  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          deb_lvl_q, deb_lvl_d;

  // A new GO level is adopted only after DebounceCycles consecutive differing samples.
  always_comb begin
    deb_cnt_d = '0;
    deb_lvl_d = deb_lvl_q;
    if (go_sync_q[1] != deb_lvl_q) begin
      if (deb_cnt_q == DW'(DebounceCycles - 1)) begin
        deb_lvl_d = go_sync_q[1];
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  assign go_level = deb_lvl_q;
`else
  logic unused_debounce;
  assign unused_debounce = |DebounceCycles;
  assign go_level        = go_sync_q[1];
`endif

  always_comb begin
    go_sync_d  = {go_sync_q[0], GO};
    run_sync_d = {run_sync_q[0], RunMode};
    lv_sync_d  = {lv_sync_q[0], pinlv};
    go_prev_d  = go_level;
    go_pulse_d = go_level & ~go_prev_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    reload  = lv_sync_q[1] ? FAST_LOAD : SLOW_LOAD;

    case (state_q)
      ST_IDLE: begin
        if (go_pulse_q) begin
          if (run_sync_q[1]) begin
            state_d = ST_RUN;
            cnt_d   = reload;
          end else begin
            state_d = ST_STEP;
            tick_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // An expiring tick is still issued when the run is paused in the same cycle.
        if (cnt_q == '0) begin
          tick_d = 1'b1;
          cnt_d  = reload;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        if (go_pulse_q || !run_sync_q[1]) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP:   state_d = ST_IDLE;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase

    if (Halt) begin
      state_d = ST_HALTED;
      tick_d  = 1'b0;
    end

    running_d    = (state_d == ST_RUN);
    halted_d     = (state_d == ST_HALTED);
    step_count_d = step_count_q + 16'(tick_d);
  end

  always_ff @(posedge GlobalClock) begin
    if (RST) begin
      go_sync_q    <= '0;
      run_sync_q   <= '0;
      lv_sync_q    <= '0;
      go_prev_q    <= 1'b0;
      go_pulse_q   <= 1'b0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      tick_q       <= 1'b0;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
      step_count_q <= '0;
`ifdef LOGISIM_DEBOUNCE_EN
      deb_cnt_q    <= '0;
      deb_lvl_q    <= 1'b0;
`endif
    end else begin
      go_sync_q    <= go_sync_d;
      run_sync_q   <= run_sync_d;
      lv_sync_q    <= lv_sync_d;
      go_prev_q    <= go_prev_d;
      go_pulse_q   <= go_pulse_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      running_q    <= running_d;
      halted_q     <= halted_d;
      step_count_q <= step_count_d;
`ifdef LOGISIM_DEBOUNCE_EN
      deb_cnt_q    <= deb_cnt_d;
      deb_lvl_q    <= deb_lvl_d;
`endif
    end
  end

  assign ClockTick = tick_q;
  assign Running   = running_q;
  assign Halted    = halted_q;
  assign StepCount = step_count_q;

endmodule

// File: tb/tb_logisim_run_controller.sv
// tb/tb_logisim_run_controller.sv - randomized scenario bench for logisim_run_controller
module tb_logisim_run_controller;

  localparam int FAST = 4;
  localparam int SLOW = 10;
  localparam int DEB  = 3;
`ifdef LOGISIM_DEBOUNCE_EN
  localparam int GO_LAT = 2 + DEB + 1;
`else
  localparam int GO_LAT = 3;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, go, run_mode, pinlv, halt;
  logic        tick, running, halted;
  logic [15:0] step_count;

  logic        w_rst, w_go, w_run_mode, w_pinlv, w_halt;
  logic        w_tick, w_running, w_halted;
  logic [15:0] w_step_count;

  logisim_run_controller #(
    .NrOfBits(32), .FastReload(FAST), .SlowReload(SLOW), .DebounceCycles(DEB)
  ) dut (
    .GlobalClock(clk), .RST(rst), .GO(go), .RunMode(run_mode), .pinlv(pinlv),
    .Halt(halt), .ClockTick(tick), .Running(running), .Halted(halted),
    .StepCount(step_count)
  );

  logisim_run_controller #(
    .NrOfBits(8), .FastReload(1), .SlowReload(1), .DebounceCycles(DEB)
  ) u_wrap (
    .GlobalClock(clk), .RST(w_rst), .GO(w_go), .RunMode(w_run_mode), .pinlv(w_pinlv),
    .Halt(w_halt), .ClockTick(w_tick), .Running(w_running), .Halted(w_halted),
    .StepCount(w_step_count)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int w_ticks = 0;
  int tick_log[$];
  int run_rise_log[$];
  int exp_q[$];
  logic running_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tick === 1'b1) tick_log.push_back(cyc);
    if (running === 1'b1 && running_prev !== 1'b1) run_rise_log.push_back(cyc);
    running_prev <= running;
    if (w_tick === 1'b1) w_ticks <= w_ticks + 1;
  end

  // A pinlv change driven at negedge p is first used by a reload on edge p+3.
  function automatic int period_at(int e, bit lv0, bit lv1, int p);
    bit lv;
    lv = (e >= p + 3) ? lv1 : lv0;
    return lv ? FAST : SLOW;
  endfunction

  // Ticks of a run entered on edge k and left on edge x (a tick on x is kept).
  function automatic void run_model(int k, int x, bit lv0, bit lv1, int p);
    int t;
    exp_q.delete();
    t = k + period_at(k, lv0, lv1, p);
    while (t <= x) begin
      exp_q.push_back(t);
      t = t + period_at(t, lv0, lv1, p);
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic step_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic press(input int len, output int t0);
    t0 = cyc;
    go = 1'b1;
    idle(len);
    go = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; go = 1'b0; halt = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    tick_log.delete();
    run_rise_log.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; halt = 1'b0;
    run_mode = 1'($urandom_range(0, 1));
    pinlv    = 1'($urandom_range(0, 1));
    idle(3);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (step_count !== 16'h0) begin errors++; $display("FAIL reset_stepcount: got %0d want 0", step_count); end
    rst = 1'b0;
    tick_log.delete();
    idle(15);
    checks++; if (tick_log.size() != 0) begin errors++; $display("FAIL reset_idle_ticks: got %0d want 0", tick_log.size()); end
  endtask

  task automatic test_run_rate_pause();
    int t0, t1, k, p, x, nt;
    int got[$];
    do_reset();
    run_mode = 1'b1; pinlv = 1'b1;
    idle(4);
    press(8, t0);
    k = t0 + GO_LAT + 1;
    step_to(k + 3 * FAST + 1);
    checks++; if (run_rise_log.size() != 1 || run_rise_log[0] != k) begin
      errors++; $display("FAIL run_entry: got %0d rises first %0d want 1 at %0d",
                         run_rise_log.size(), (run_rise_log.size() > 0) ? run_rise_log[0] : -1, k);
    end
    checks++; if (step_count !== 16'd3) begin errors++; $display("FAIL run_stepcount3: got %0d want 3", step_count); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_running: got %b want 1", running); end
    p = cyc;
    pinlv = 1'b0;
    nt = $urandom_range(2, 3);
    step_to(k + 4 * FAST + nt * SLOW - $urandom_range(2, 8));
    press(8, t1);
    x = t1 + GO_LAT + 1;
    idle(25);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_running: got %b want 0", running); end
    run_model(k, x, 1'b1, 1'b0, p);
    got = tick_log.find with (item >= k && item < cyc);
    checks++; if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL rate_tick_count: got %0d want %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] != exp_q[i]) begin
        errors++; $display("FAIL rate_tick[%0d]: got cycle %0d want %0d", i, got[i], exp_q[i]);
      end
    end
    checks++; if (step_count !== 16'(exp_q.size())) begin
      errors++; $display("FAIL pause_stepcount: got %0d want %0d", step_count, exp_q.size());
    end
  endtask

  task automatic test_single_step();
    int t0, start;
    int got[$];
    do_reset();
    run_mode = 1'b0; pinlv = 1'($urandom_range(0, 1));
    idle(4);
    start = cyc;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      press($urandom_range(DEB + 2, 10), t0);
      exp_q.push_back(t0 + GO_LAT + 1);
      idle($urandom_range(4, 8));
    end
`ifdef LOGISIM_DEBOUNCE_EN
    press(2, t0);
    idle(12);
`endif
    idle(4);
    got = tick_log.find with (item >= start && item < cyc);
    checks++; if (got.size() != 3) begin errors++; $display("FAIL step_tick_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i] != exp_q[i]) begin
        errors++; $display("FAIL step_tick[%0d]: got cycle %0d want %0d", i, got[i], exp_q[i]);
      end
    end
    checks++; if (run_rise_log.size() != 0) begin errors++; $display("FAIL step_running: got %0d rises want 0", run_rise_log.size()); end
    checks++; if (step_count !== 16'd3) begin errors++; $display("FAIL step_stepcount: got %0d want 3", step_count); end
  endtask

  task automatic test_halt_priority();
    int t0, t1, k, nh, th;
    int got[$];
    do_reset();
    run_mode = 1'b1; pinlv = 1'b1;
    idle(4);
    press(8, t0);
    k  = t0 + GO_LAT + 1;
    nh = $urandom_range(2, 4);
    th = k + nh * FAST;
    step_to(th - 1);
    halt = 1'b1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b want 0", halted); end
    idle(1);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_halted: got %b want 1", halted); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL halt_tick_suppressed: got %b want 0", tick); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL halt_running: got %b want 0", running); end
    idle($urandom_range(0, 2));
    halt = 1'b0;
    press(8, t1);
    idle(15);
    checks++; if (halted !== 1'b1 || running !== 1'b0) begin
      errors++; $display("FAIL halt_go_ignored: got halted=%b running=%b want 1 0", halted, running);
    end
    checks++; if (step_count !== 16'(nh - 1)) begin
      errors++; $display("FAIL halt_stepcount: got %0d want %0d", step_count, nh - 1);
    end
    got = tick_log.find with (item >= k && item < cyc);
    checks++; if (got.size() != nh - 1) begin errors++; $display("FAIL halt_tick_count: got %0d want %0d", got.size(), nh - 1); end
    for (int i = 0; i < nh - 1 && i < got.size(); i++) begin
      checks++; if (got[i] != k + (i + 1) * FAST) begin
        errors++; $display("FAIL halt_tick[%0d]: got cycle %0d want %0d", i, got[i], k + (i + 1) * FAST);
      end
    end
    rst = 1'b1;
    idle(1);
    checks++; if (halted !== 1'b0 || step_count !== 16'h0) begin
      errors++; $display("FAIL halt_reset: got halted=%b stepcount=%0d want 0 0", halted, step_count);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_reset_mid_run();
    int t0, k, m, r, tn;
    bit lv;
    int got[$];
    do_reset();
    lv = 1'($urandom_range(0, 1));
    run_mode = 1'b1; pinlv = lv;
    r = lv ? FAST : SLOW;
    idle(4);
    press(8, t0);
    k  = t0 + GO_LAT + 1;
    m  = $urandom_range(1, 3);
    tn = k + (m + 1) * r;
    step_to(tn - 1);
    rst = 1'b1;
    idle(1);
    checks++; if (tick !== 1'b0 || running !== 1'b0 || halted !== 1'b0 || step_count !== 16'h0) begin
      errors++; $display("FAIL midrun_reset: got tick=%b run=%b halt=%b cnt=%0d want all 0",
                         tick, running, halted, step_count);
    end
    rst = 1'b0;
    idle(5);
    got = tick_log.find with (item >= k && item < cyc);
    checks++; if (got.size() != m) begin errors++; $display("FAIL midrun_tick_count: got %0d want %0d", got.size(), m); end
  endtask

  task automatic test_wrap();
    int t0, k, base;
    w_go = 1'b0; w_halt = 1'b0; w_run_mode = 1'b1; w_pinlv = 1'b1;
    idle(3);
    w_rst = 1'b0;
    idle(4);
    checks++; if (w_step_count !== 16'h0) begin errors++; $display("FAIL wrap_start: got %0d want 0", w_step_count); end
    base = w_ticks;
    t0 = cyc;
    w_go = 1'b1;
    idle(8);
    w_go = 1'b0;
    k = t0 + GO_LAT + 1;
    step_to(k + 100);
    checks++; if (w_running !== 1'b1) begin errors++; $display("FAIL wrap_running: got %b want 1", w_running); end
    step_to(k + 65536);
    w_halt = 1'b1;
    idle(3);
    checks++; if (w_ticks - base != 65536) begin
      errors++; $display("FAIL wrap_tick_total: got %0d want 65536", w_ticks - base);
    end
    checks++; if (w_step_count !== 16'h0000) begin
      errors++; $display("FAIL wrap_stepcount: got %0d want 0", w_step_count);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; go = 1'b0; run_mode = 1'b0; pinlv = 1'b0; halt = 1'b0;
    w_rst = 1'b1; w_go = 1'b0; w_run_mode = 1'b0; w_pinlv = 1'b0; w_halt = 1'b0;
    @(negedge clk);
    test_reset();
    test_run_rate_pause();
    test_single_step();
    test_halt_priority();
    test_reset_mid_run();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
